pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Next-PC controller that sequences the program counter register. Each cycle it selects next_pc from sequential increment, branch, jump, call/return, interrupt entry, stall-hold or halt. It owns a small return-address stack (RAS) and the interrupt-entry FSM. next_pc feeds the PC register directly, and pc_in is that register's current output.

Parameters:
RESET_VECTOR, 16'h0000, next_pc value issued in BOOT state.
INT_VECTOR, 16'h0010, interrupt service entry address.
RAS_DEPTH, 4, return-address stack entries (>=2).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high
pc_in  in  16  current PC from PC register
stall  in  1  hold PC (fetch not ready)
halt  in  1  enter low-power halt
branch_taken  in  1  conditional branch resolved taken
branch_target  in  16  branch destination
jump  in  1  unconditional jump
jump_target  in  16  jump/call destination
call  in  1  call: push pc_in+1, go to jump_target
ret  in  1  return: pop RAS into next_pc
irq  in  1  level interrupt request
next_pc  out  16  combinational next PC
irq_ack  out  1  one-cycle pulse on interrupt vector issue
in_isr  out  1  inside interrupt handler (masks irq)
halted  out  1  FSM in HALTED
ras_count  out  $clog2(RAS_DEPTH+1)  RAS occupancy
ras_overflow  out  1  sticky: push attempted while full
ras_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async): state=BOOT, RAS empty, ras_count=0, in_isr=0, both sticky flags=0, irq_ack=0. During reset and BOOT, next_pc=RESET_VECTOR and halted=0.
- FSM states: BOOT, RUN, IRQ_ENTRY, HALTED.
- BOOT: after one cycle, go to RUN unconditionally. All inputs are ignored.
- RUN priority (highest first): irq accept > halt > stall > ret > call > jump > branch_taken > sequential.
  - Interrupt accept requires irq=1, in_isr=0, stall=0, ras_count<RAS_DEPTH.
  - On accept: push pc_in+1, next_pc=pc_in (hold), go to IRQ_ENTRY.
  - If irq=1 and the RAS is full, the interrupt is held off (no overflow flag). Normal priority then applies.
  - halt: next_pc=pc_in, go to HALTED.
  - stall: next_pc=pc_in. No RAS change.
  - ret, RAS not empty: pop; next_pc=popped value. If in_isr=1, clear in_isr on the same edge.
  - ret, RAS empty: next_pc=pc_in+1, set ras_underflow.
  - call: next_pc=jump_target. Push pc_in+1 if not full. If full, the push is dropped and ras_overflow is set; the jump still happens.
  - ret+call in the same cycle: ret wins, call is ignored.
  - jump: next_pc=jump_target. branch_taken: next_pc=branch_target.
  - Sequential: next_pc=pc_in+1, 16-bit modular (16'hFFFF -> 16'h0000).
- IRQ_ENTRY:
  - If stall=1: next_pc=pc_in and stay in IRQ_ENTRY.
  - Else: next_pc=INT_VECTOR, irq_ack=1 this cycle only, in_isr<=1, go to RUN.
  - halt, call, ret, jump and branch are ignored in this state.
- HALTED: next_pc=pc_in and halted=1.
  - Wake when irq=1, in_isr=0 and the RAS is not full: push pc_in+1, go to IRQ_ENTRY.
  - Otherwise stay. halt is irrelevant in this state.
- ras_count saturates at 0 and RAS_DEPTH. It never over- or under-counts.
- Sticky flags clear only on reset.
- Interrupt latency: irq sampled in RUN -> INT_VECTOR on next_pc exactly one cycle later, with no stall.

Decomposition:
- Shared package cpu_pkg: FSM state enum (BOOT, RUN, IRQ_ENTRY, HALTED), PC_W=16, default vector constants.
- One sub-module: ras_stack, a LIFO of RAS_DEPTH x 16.
  - Inputs: push, pop, din. Outputs: top, count, full, empty.
  - push and pop are never asserted together by the sequencer.

Test Plan:
- Reset then release, pc_in=0 -> next_pc=16'h0000 during BOOT. RUN with pc_in=16'h0000 -> next_pc=16'h0001. pc_in=16'hFFFF -> 16'h0000.
- pc_in=16'h0020, call, jump_target=16'h0100 -> next_pc=16'h0100, ras_count=1. Then pc_in=16'h0105, ret -> next_pc=16'h0021, ras_count=0.
- RAS_DEPTH+1 nested calls -> ras_overflow=1, ras_count=4, last push dropped. Five rets -> fifth gives next_pc=pc_in+1 and ras_underflow=1.
- pc_in=16'h0040, irq=1 -> cycle0 next_pc=16'h0040. Cycle1 next_pc=16'h0010 with irq_ack=1, in_isr=1. Second irq ignored. ret -> next_pc=16'h0041, in_isr=0.
- halt at pc_in=16'h0050 -> halted=1, next_pc held. irq -> IRQ_ENTRY; next cycle next_pc=16'h0010; later ret -> next_pc=16'h0051.
- Both irq and stall in IRQ_ENTRY for 3 cycles -> next_pc=pc_in, irq_ack=0 throughout. Stall release -> INT_VECTOR with a single irq_ack pulse. Reset asserted in IRQ_ENTRY -> BOOT, RAS empty, in_isr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared PC width, default vectors and sequencer FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int PC_W = 16;

   localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 16'h0000;
   localparam logic [PC_W-1:0] DEF_INT_VECTOR   = 16'h0010;
   localparam int              DEF_RAS_DEPTH    = 4;

   typedef enum logic [1:0] {
      ST_BOOT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_IRQ_ENTRY = 2'd2,
      ST_HALTED    = 2'd3
   } seq_state_t;

   // Modular increment; 16'hFFFF wraps to 16'h0000.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module : pc_sequencer_if
// Brief  : Control/status bundle between the core and the next-PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
   parameter int CNT_W = 3
);
   import cpu_pkg::*;

   logic [PC_W-1:0]  pc_in;
   logic             stall;
   logic             halt;
   logic             branch_taken;
   logic [PC_W-1:0]  branch_target;
   logic             jump;
   logic [PC_W-1:0]  jump_target;
   logic             call;
   logic             ret;
   logic             irq;

   logic [PC_W-1:0]  next_pc;
   logic             irq_ack;
   logic             in_isr;
   logic             halted;
   logic [CNT_W-1:0] ras_count;
   logic             ras_overflow;
   logic             ras_underflow;

   modport master (
      output pc_in, stall, halt, branch_taken, branch_target,
             jump, jump_target, call, ret, irq,
      input  next_pc, irq_ack, in_isr, halted, ras_count,
             ras_overflow, ras_underflow
   );

   modport slave (
      input  pc_in, stall, halt, branch_taken, branch_target,
             jump, jump_target, call, ret, irq,
      output next_pc, irq_ack, in_isr, halted, ras_count,
             ras_overflow, ras_underflow
   );

endinterface

`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
// ============================================================================
// Module : ras_stack
// Brief  : Return-address LIFO; count saturates at 0 and DEPTH.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack
   import cpu_pkg::*;
#(
   parameter  int DEPTH = DEF_RAS_DEPTH,
   parameter  int W     = PC_W,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_push,
   input  wire logic             i_pop,
   input  wire logic [W-1:0]     i_din,
   output logic      [W-1:0]     o_top,
   output logic      [CNT_W-1:0] o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_rd_cnt;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_rd_idx;
   logic             w_full;
   logic             w_empty;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_rd_cnt = r_count - CNT_W'(1);
   assign w_wr_idx = r_count[IDX_W-1:0];
   assign w_rd_idx = w_rd_cnt[IDX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push && !w_full) begin
         r_mem[w_wr_idx] <= i_din;
         r_count         <= r_count + CNT_W'(1);
      end else if (i_pop && !w_empty) begin
         r_count <= w_rd_cnt;
      end
   end

   assign o_top   = r_mem[w_rd_idx];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Next-PC selection with call/return stack and interrupt entry FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [PC_W-1:0] INT_VECTOR   = DEF_INT_VECTOR,
   parameter int              RAS_DEPTH    = DEF_RAS_DEPTH
) (
   input  wire logic          clk,
   input  wire logic          reset,
   pc_sequencer_if.slave      bus
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic             r_in_isr;
   logic             r_ras_ovf;
   logic             r_ras_unf;

   logic [PC_W-1:0]  w_pc_inc;
   logic [PC_W-1:0]  w_next_pc;
   logic             w_irq_ack;
   logic             w_push;
   logic             w_pop;
   logic             w_set_isr;
   logic             w_clr_isr;
   logic             w_set_ovf;
   logic             w_set_unf;
   logic             w_irq_ok;

   logic [PC_W-1:0]  w_ras_top;
   logic [CNT_W-1:0] w_ras_count;
   logic             w_ras_full;
   logic             w_ras_empty;

   ras_stack #(
      .DEPTH   (RAS_DEPTH),
      .W       (PC_W)
   ) u_ras (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_pc_inc),
      .o_top   (w_ras_top),
      .o_count (w_ras_count),
      .o_full  (w_ras_full),
      .o_empty (w_ras_empty)
   );

   assign w_pc_inc = pc_inc(bus.pc_in);
   // A full stack holds the interrupt off so its return address is never lost.
   assign w_irq_ok = bus.irq && !r_in_isr && !w_ras_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_BOOT;
         r_in_isr  <= 1'b0;
         r_ras_ovf <= 1'b0;
         r_ras_unf <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_set_isr) begin
            r_in_isr <= 1'b1;
         end else if (w_clr_isr) begin
            r_in_isr <= 1'b0;
         end
         if (w_set_ovf) begin
            r_ras_ovf <= 1'b1;
         end
         if (w_set_unf) begin
            r_ras_unf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_next_pc   = bus.pc_in;
      w_irq_ack   = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_set_isr   = 1'b0;
      w_clr_isr   = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;

      unique case (r_state)
         ST_BOOT: begin
            w_next_pc   = RESET_VECTOR;
            w_state_nxt = ST_RUN;
         end

         ST_RUN: begin
            if (w_irq_ok && !bus.stall) begin
               w_push      = 1'b1;
               w_state_nxt = ST_IRQ_ENTRY;
            end else if (bus.halt) begin
               w_state_nxt = ST_HALTED;
            end else if (bus.stall) begin
               w_next_pc = bus.pc_in;
            end else if (bus.ret) begin
               if (!w_ras_empty) begin
                  w_pop     = 1'b1;
                  w_next_pc = w_ras_top;
                  w_clr_isr = r_in_isr;
               end else begin
                  w_next_pc = w_pc_inc;
                  w_set_unf = 1'b1;
               end
            end else if (bus.call) begin
               w_next_pc = bus.jump_target;
               if (!w_ras_full) begin
                  w_push = 1'b1;
               end else begin
                  w_set_ovf = 1'b1;
               end
            end else if (bus.jump) begin
               w_next_pc = bus.jump_target;
            end else if (bus.branch_taken) begin
               w_next_pc = bus.branch_target;
            end else begin
               w_next_pc = w_pc_inc;
            end
         end

         ST_IRQ_ENTRY: begin
            if (!bus.stall) begin
               w_next_pc   = INT_VECTOR;
               w_irq_ack   = 1'b1;
               w_set_isr   = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end

         ST_HALTED: begin
            if (w_irq_ok) begin
               w_push      = 1'b1;
               w_state_nxt = ST_IRQ_ENTRY;
            end
         end

         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   assign bus.next_pc       = w_next_pc;
   assign bus.irq_ack       = w_irq_ack;
   assign bus.in_isr        = r_in_isr;
   assign bus.halted        = (r_state == ST_HALTED);
   assign bus.ras_count     = w_ras_count;
   assign bus.ras_overflow  = r_ras_ovf;
   assign bus.ras_underflow = r_ras_unf;

endmodule

`default_nettype wire
